// File: rtl/disp_req_arbiter_pkg.sv
// Shared constants for the display request arbiter: state encoding,
// default parameter values and the byte width carried to the display.
package disp_req_arbiter_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_GAP_CYCLES = 1;
    localparam int DEF_CNT_W      = 11;
    localparam int BYTE_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/disp_req_arbiter_rr_sel.sv
// Round-robin search: first set request strictly after the last grant,
// wrapping through the whole vector so the last grantee comes last.
module rr_priority_sel #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   sel
);

    logic [IDX_W:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the one kept.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = {1'b0, last} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/disp_req_arbiter.sv
// Shares the seven-segment display controller between byte producers:
// one grant per ISSUE, then GAP idle cycles so the controller can commit it.
module disp_req_arbiter
    import disp_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [BYTE_W-1:0]          disp_data,
    output logic                       disp_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [CNT_W-1:0]           issued_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [BYTE_W-1:0]  disp_data_q, disp_data_d;
    logic               disp_valid_q, disp_valid_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   issued_cnt_q, issued_cnt_d;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [BYTE_W-1:0]  req_bytes [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_bytes[gi] = req_data[gi*BYTE_W +: BYTE_W];
    end

    rr_priority_sel #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req   (req),
        .last  (last_q),
        .found (sel_found),
        .sel   (sel_idx)
    );

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        last_d       = last_q;
        grant_id_d   = grant_id_q;
        ack_d        = '0;
        disp_data_d  = disp_data_q;
        disp_valid_d = 1'b0;
        issued_cnt_d = issued_cnt_q;

        case (state_q)
            IDLE: begin
                if (en && sel_found) begin
                    disp_data_d     = req_bytes[sel_idx];
                    disp_valid_d    = 1'b1;
                    ack_d[sel_idx]  = 1'b1;
                    grant_id_d      = sel_idx;
                    last_d          = sel_idx;
                    issued_cnt_d    = issued_cnt_q + CNT_W'(1);
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                state_d   = GAP;
            end
            GAP: begin
                // Requests are ignored here so a just-acked producer is not re-granted.
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            last_q       <= IDX_W'(NUM_REQ - 1);
            grant_id_q   <= IDX_W'(NUM_REQ - 1);
            ack_q        <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            issued_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            last_q       <= last_d;
            grant_id_q   <= grant_id_d;
            ack_q        <= ack_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign ack        = ack_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_disp_req_arbiter.sv
// Directed bench for disp_req_arbiter: one instance with a one-cycle gap and
// one with a three-cycle gap, driven from the same request inputs.
module tb_disp_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_data;

    logic [3:0]  ack_a, ack_b;
    logic [7:0]  data_a, data_b;
    logic        valid_a, valid_b;
    logic [1:0]  gid_a, gid_b;
    logic        busy_a, busy_b;
    logic [10:0] cnt_a, cnt_b;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    disp_req_arbiter #(.NUM_REQ(4), .GAP_CYCLES(1), .CNT_W(11)) dut_a (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
        .ack(ack_a), .disp_data(data_a), .disp_valid(valid_a),
        .grant_id(gid_a), .busy(busy_a), .issued_cnt(cnt_a)
    );

    disp_req_arbiter #(.NUM_REQ(4), .GAP_CYCLES(3), .CNT_W(11)) dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
        .ack(ack_b), .disp_data(data_b), .disp_valid(valid_b),
        .grant_id(gid_b), .busy(busy_b), .issued_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks_cnt++;
        if (obs !== expv) begin
            errors_cnt++;
            $display("FAIL %s observed=%0h required=%0h", tag, obs, expv);
        end else begin
            $display("ok   %s value=%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!valid_a && n < 8);
        if (!valid_a) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        return 8'(8'h10 + 8'h11 * k);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, na, nb, ta, tb, bad, exp_g;
        rst = 1'b1; en = 1'b0; req = 4'b0; req_data = 32'h0;
        step(); step();
        check("rst_valid", valid_a, 1'b0);
        check("rst_data", data_a, 8'h00);
        check("rst_ack", ack_a, 4'b0000);
        check("rst_gid", gid_a, 2'd3);
        check("rst_busy", busy_a, 1'b0);
        check("rst_cnt", cnt_a, 11'd0);

        // Single requester, byte A5 on lane 2
        rst = 1'b0; en = 1'b1; req = 4'b0100; req_data = 32'h00A5_0000;
        step();
        check("single_valid", valid_a, 1'b1);
        check("single_data", data_a, 8'hA5);
        check("single_ack", ack_a, 4'b0100);
        check("single_gid", gid_a, 2'd2);
        check("single_cnt", cnt_a, 11'd1);
        check("single_busy", busy_a, 1'b1);
        req = 4'b0000;
        step();
        check("gap_valid", valid_a, 1'b0);
        check("gap_ack", ack_a, 4'b0000);
        check("gap_busy", busy_a, 1'b1);
        step();
        check("idle_valid", valid_a, 1'b0);
        check("idle_busy", busy_a, 1'b0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (valid_a || ack_a != 4'b0) bad++;
        end
        check("no_regrant", bad, 0);
        check("single_cnt_hold", cnt_a, 11'd1);
        check("single_data_hold", data_a, 8'hA5);

        // All requesters held: strict rotation, spacing GAP+2
        rst = 1'b1; #1; rst = 1'b0;
        req = 4'b1111; req_data = 32'h4332_2110;
        na = 0; nb = 0; ta = 0; tb = 0;
        for (int t = 1; t <= 15; t++) begin
            step();
            if (valid_a) begin
                check($sformatf("rot_a_gid%0d", na), gid_a, na % 4);
                check($sformatf("rot_a_data%0d", na), data_a, exp_byte(na % 4));
                check($sformatf("rot_a_ack%0d", na), ack_a, 4'b1 << (na % 4));
                if (na > 0) check($sformatf("rot_a_space%0d", na), t - ta, 3);
                ta = t; na++;
            end
            if (valid_b) begin
                check($sformatf("rot_b_gid%0d", nb), gid_b, nb % 4);
                if (nb > 0) check($sformatf("rot_b_space%0d", nb), t - tb, 5);
                tb = t; nb++;
            end
        end
        check("rot_a_count", na, 5);
        check("rot_b_count", nb, 3);
        check("rot_a_cnt", cnt_a, 11'd5);

        // Requesters 0 and 3 only, last grant was 0: alternate 3,0,...
        req = 4'b1001;
        for (int i = 0; i < 20; i++) begin
            wait_pulse("alt", n);
            exp_g = (i % 2 == 0) ? 3 : 0;
            check($sformatf("alt_gid%0d", i), gid_a, exp_g);
            check($sformatf("alt_data%0d", i), data_a, exp_byte(exp_g));
        end

        // Enable low blocks grants; in-flight sequence finishes
        en = 1'b0; req = 4'b1111;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid_a || ack_a != 4'b0) bad++;
        end
        check("en_blocked", bad, 0);
        en = 1'b1;
        step();
        check("en_valid", valid_a, 1'b1);
        check("en_gid", gid_a, 2'd1);
        check("en_ack", ack_a, 4'b0010);

        // Asynchronous reset while in ISSUE
        rst = 1'b1; #1;
        check("arst_valid", valid_a, 1'b0);
        check("arst_ack", ack_a, 4'b0000);
        check("arst_cnt", cnt_a, 11'd0);
        check("arst_gid", gid_a, 2'd3);
        step();
        rst = 1'b0;
        step();
        check("post_rst_valid", valid_a, 1'b1);
        check("post_rst_gid", gid_a, 2'd0);
        check("post_rst_cnt", cnt_a, 11'd1);

        // Counter wrap over 2048 grants
        rst = 1'b1; #1; rst = 1'b0;
        bad = 0;
        for (int k = 1; k <= 2048; k++) begin
            wait_pulse("wrap", n);
            if (gid_a != 2'((k - 1) % 4)) bad++;
            if (data_a != exp_byte((k - 1) % 4)) bad++;
            if (n != ((k == 1) ? 1 : 3)) bad++;
            if (k == 2047) check("wrap_cnt_2047", cnt_a, 11'd2047);
            if (k == 2048) check("wrap_cnt_0", cnt_a, 11'd0);
        end
        check("wrap_order", bad, 0);
        check("wrap_gid", gid_a, 2'd3);
        wait_pulse("wrap_next", n);
        check("wrap_next_cnt", cnt_a, 11'd1);
        check("wrap_next_gid", gid_a, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
